add_share_arb: RTL and testbench

ADD_SHARE_ARB -- requirements
Module: add_share_arb

---
 rtl/add_share_pkg.sv | 15 +
 rtl/BrentKung.sv | 46 ++++
 rtl/rr_arbiter.sv | 28 ++
 rtl/add_share_arb.sv | 102 ++++++++++
 tb/tb_add_share_arb.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/add_share_pkg.sv
// Shared types and widths for the time-shared 12-bit adder arbiter.
package add_share_pkg;
    localparam int ADD_W = 12;
    localparam int SUM_W = 13;

    typedef enum logic {
        IDLE = 1'b0,
        FULL = 1'b1
    } state_e;

    typedef struct packed {
        logic [ADD_W-1:0] a;
        logic [ADD_W-1:0] b;
    } opnd_pair_t;
endpackage

// File: rtl/BrentKung.sv
// 12-bit Brent-Kung prefix adder; operands interleaved on INPUTS, carry-out on OUTS[12].
module BrentKung
    import add_share_pkg::*;
(
    input  logic [2*ADD_W-1:0] INPUTS,
    output logic [SUM_W-1:0]   OUTS
);
    logic [ADD_W-1:0] w_a;
    logic [ADD_W-1:0] w_b;
    logic [ADD_W-1:0] w_p0;
    logic [ADD_W-1:0] w_g;
    logic [ADD_W-1:0] w_p;
    logic [ADD_W:0]   w_c;

    always_comb begin
        for (int k = 0; k < ADD_W; k++) begin
            w_a[k] = INPUTS[2*k];
            w_b[k] = INPUTS[2*k+1];
        end
        w_p0 = w_a ^ w_b;
        w_g  = w_a & w_b;
        w_p  = w_p0;
        // Up-sweep builds power-of-two group (G,P); down-sweep fills the remaining prefixes.
        for (int d = 1; d < ADD_W; d = d * 2) begin
            for (int i = 0; i < ADD_W; i++) begin
                if (((i + 1) % (2 * d)) == 0) begin
                    w_g[i] = w_g[i] | (w_p[i] & w_g[i-d]);
                    w_p[i] = w_p[i] & w_p[i-d];
                end
            end
        end
        for (int d = 8; d >= 1; d = d / 2) begin
            for (int i = 0; i < ADD_W; i++) begin
                if ((((i + 1) % (2 * d)) == d) && ((i + 1) >= 3 * d)) begin
                    w_g[i] = w_g[i] | (w_p[i] & w_g[i-d]);
                    w_p[i] = w_p[i] & w_p[i-d];
                end
            end
        end
        w_c[0] = 1'b0;
        for (int i = 0; i < ADD_W; i++) begin
            w_c[i+1] = w_g[i];
        end
        OUTS = {w_c[ADD_W], w_p0 ^ w_c[ADD_W-1:0]};
    end
endmodule

// File: rtl/rr_arbiter.sv
// Round-robin search starting at ptr, wrapping at N_REQ-1; one-hot grant plus encoded index.
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 3
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic [N_REQ-1:0] grant,
    output logic [ID_W-1:0]  idx
);
    logic w_found;
    int   w_j;

    always_comb begin
        grant   = '0;
        idx     = '0;
        w_found = 1'b0;
        w_j     = 0;
        for (int k = 0; k < N_REQ; k++) begin
            w_j = (int'(ptr) + k) % N_REQ;
            if (!w_found && req[w_j]) begin
                w_found    = 1'b1;
                grant[w_j] = 1'b1;
                idx        = ID_W'(w_j);
            end
        end
    end
endmodule

// File: rtl/add_share_arb.sv
// One shared Brent-Kung adder behind a round-robin arbiter with a one-entry result buffer.
// Optional build macro ADD_SHARE_ARB_SAT_EN saturates carry-out results to 13'h0FFF.
module add_share_arb
    import add_share_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [N_REQ*ADD_W-1:0] req_a,
    input  logic [N_REQ*ADD_W-1:0] req_b,
    output logic [N_REQ-1:0]       req_ready,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [SUM_W-1:0]       res_sum,
    output logic [ID_W-1:0]        res_id
);
    state_e            r_state;
    state_e            w_state_nxt;
    logic [ID_W-1:0]   r_rr_ptr;
    logic [SUM_W-1:0]  r_sum_p1;
    logic [ID_W-1:0]   r_id_p1;
    logic [N_REQ-1:0]  w_grant_oh;
    logic [ID_W-1:0]   w_idx;
    logic              w_can_accept;
    logic              w_grant;
    opnd_pair_t        w_pair;
    logic [2*ADD_W-1:0] w_bk_in;
    logic [SUM_W-1:0]  w_bk_out;

    function automatic logic [SUM_W-1:0] sat_sum(input logic [SUM_W-1:0] s);
`ifdef ADD_SHARE_ARB_SAT_EN
        return s[SUM_W-1] ? {1'b0, {ADD_W{1'b1}}} : s;
`else
        return s;
`endif
    endfunction

    rr_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W)) u_arb (
        .req   (req_valid),
        .ptr   (r_rr_ptr),
        .grant (w_grant_oh),
        .idx   (w_idx)
    );

    assign res_valid    = (r_state == FULL);
    assign w_can_accept = !res_valid || res_ready;
    assign w_grant      = (|w_grant_oh) && w_can_accept && !rst;
    assign req_ready    = w_grant ? w_grant_oh : '0;

    // Stage p0: granted operand mux feeding the adder directly, no operand register.
    always_comb begin
        w_pair.a = req_a[ADD_W*int'(w_idx) +: ADD_W];
        w_pair.b = req_b[ADD_W*int'(w_idx) +: ADD_W];
        for (int k = 0; k < ADD_W; k++) begin
            w_bk_in[2*k]   = w_pair.a[k];
            w_bk_in[2*k+1] = w_pair.b[k];
        end
    end

    BrentKung u_bk (
        .INPUTS (w_bk_in),
        .OUTS   (w_bk_out)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_grant) w_state_nxt = FULL;
            FULL:    if (res_ready && !w_grant) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_rr_ptr <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_grant) begin
                r_rr_ptr <= (int'(w_idx) == N_REQ - 1) ? '0 : w_idx + 1'b1;
            end
        end
    end

    // Stage p1: result buffer; holds while the consumer stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sum_p1 <= '0;
            r_id_p1  <= '0;
        end else if (w_grant) begin
            r_sum_p1 <= sat_sum(w_bk_out);
            r_id_p1  <= w_idx;
        end
    end

    assign res_sum = r_sum_p1;
    assign res_id  = r_id_p1;
endmodule

// File: tb/tb_add_share_arb.sv
// Scoreboard bench for add_share_arb: a reference round-robin model predicts grants and results.
module tb_add_share_arb;
    localparam int N = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  req_valid;
    logic [N*12-1:0] req_a;
    logic [N*12-1:0] req_b;
    logic [N-1:0]  req_ready;
    logic          res_valid;
    logic          res_ready;
    logic [12:0]   res_sum;
    logic [2:0]    res_id;

    typedef struct {
        int id;
        int sum;
    } exp_t;

    exp_t q[$];
    int   m_ptr  = 0;
    bit   m_full = 1'b0;
    int   n_tot  = 0;
    int   n_bad  = 0;

    always #5 clk = ~clk;

    add_share_arb #(.N_REQ(N), .ID_W(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_sum   (res_sum),
        .res_id    (res_id)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int exp_sum(input int a, input int b);
        int s;
        s = a + b;
`ifdef ADD_SHARE_ARB_SAT_EN
        if (s > 32'hFFF) s = 32'hFFF;
`endif
        return s;
    endfunction

    function automatic int pick(input logic [N-1:0] v, input int ptr);
        for (int k = 0; k < N; k++) begin
            if (v[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    task automatic rand_ops();
        for (int i = 0; i < N; i++) begin
            req_a[12*i +: 12] = 12'($urandom);
            req_b[12*i +: 12] = 12'($urandom);
        end
    endtask

    // Called just after a falling edge with inputs already driven; returns at the next falling edge.
    task automatic cycle();
        int g;
        logic [N-1:0] oh;
        exp_t e;
        #1;
        g = -1;
        if (!rst && (!m_full || res_ready)) g = pick(req_valid, m_ptr);
        oh = (g >= 0) ? N'(1 << g) : '0;
        chk("req_ready", 32'(req_ready), 32'(oh));
        chk("res_valid", 32'(res_valid), 32'(m_full));
        if (m_full) begin
            chk("res_sum", 32'(res_sum), 32'(q[0].sum));
            chk("res_id", 32'(res_id), 32'(q[0].id));
        end
        if (rst) begin
            q.delete();
            m_full = 1'b0;
            m_ptr  = 0;
        end else begin
            if (m_full && res_ready) void'(q.pop_front());
            if (g >= 0) begin
                e.id  = g;
                e.sum = exp_sum(int'(req_a[12*g +: 12]), int'(req_b[12*g +: 12]));
                q.push_back(e);
                m_ptr = (g + 1) % N;
            end
            m_full = (q.size() > 0);
        end
        @(negedge clk);
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        res_ready = 1'b1;
        @(negedge clk);
        cycle();
        cycle();
        rst = 1'b0;
        #1;
        chk("rst_valid", 32'(res_valid), 32'd0);
        chk("rst_sum", 32'(res_sum), 32'd0);
        chk("rst_id", 32'(res_id), 32'd0);

        // single request on port 2
        req_valid = 4'b0100;
        req_a[24 +: 12] = 12'h0FF;
        req_b[24 +: 12] = 12'h001;
        #1;
        chk("single_rdy", 32'(req_ready), 32'h4);
        cycle();
        req_valid = '0;
        #1;
        chk("single_sum", 32'(res_sum), 32'h100);
        chk("single_id", 32'(res_id), 32'd2);
        cycle();

        // carry-out on port 0
        req_valid = 4'b0001;
        req_a[0 +: 12] = 12'hFFF;
        req_b[0 +: 12] = 12'h001;
        cycle();
        req_valid = '0;
        #1;
`ifdef ADD_SHARE_ARB_SAT_EN
        chk("carry_sum", 32'(res_sum), 32'h0FFF);
`else
        chk("carry_sum", 32'(res_sum), 32'h1000);
`endif
        cycle();

        // fairness from a fresh pointer
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        req_valid = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            rand_ops();
            #1;
            chk("fair_grant", 32'(req_ready), 32'(1 << (k % 4)));
            if (k > 0) chk("fair_id", 32'(res_id), 32'((k - 1) % 4));
            cycle();
        end

        // backpressure: result must hold, nothing accepted
        res_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            rand_ops();
            #1;
            chk("bp_ready", 32'(req_ready), 32'd0);
            cycle();
        end
        res_ready = 1'b1;
        #1;
        chk("bp_release", 32'(req_ready), 32'h1);
        cycle();

        // random traffic
        for (int k = 0; k < 300; k++) begin
            req_valid = N'($urandom);
            res_ready = ($urandom_range(0, 3) != 0);
            rand_ops();
            cycle();
        end

        // reset while a result is buffered
        req_valid = 4'b1111;
        res_ready = 1'b1;
        rand_ops();
        cycle();
        rst = 1'b1;
        req_valid = 4'b0000;
        cycle();
        rst = 1'b0;
        req_valid = 4'b1010;
        rand_ops();
        #1;
        chk("mid_rst_valid", 32'(res_valid), 32'd0);
        chk("mid_rst_grant", 32'(req_ready), 32'h2);
        cycle();
        req_valid = '0;
        cycle();
        cycle();

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end
endmodule
